// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write sequencer.
package lcd_pkg;

   // Write-cycle phases of the sequencer FSM.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_EXEC  = 3'd4
   } lcd_state_e;

   // Bit positions inside the CPU's 32-bit LCD register.
   localparam int LCD_ON_BIT = 31;
   localparam int LCD_EN_BIT = 10;
   localparam int LCD_RS_BIT = 9;
   localparam int LCD_RW_BIT = 8;

   // Commands that need the long execution wait.
   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
   localparam logic [7:0] LCD_CMD_HOME2 = 8'h03;

   // One queued write: register select plus data byte.
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_entry_t;

   // True when the entry is a clear/home command (RS=0, DATA 0x01..0x03).
   function automatic logic is_long_cmd(input lcd_entry_t e);
      return (e.rs == 1'b0) &&
             ((e.data == LCD_CMD_CLEAR) || (e.data == LCD_CMD_HOME) ||
              (e.data == LCD_CMD_HOME2));
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic [AW:0]      level_d;
   logic             do_push_s;
   logic             do_pop_s;
   logic             full_s;
   logic             empty_s;

   assign full_s    = (level_q == (AW+1)'(DEPTH));
   assign empty_s   = (level_q == {(AW+1){1'b0}});
   assign do_pop_s  = pop_i & ~empty_s;
   // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
   assign do_push_s = push_i & (~full_s | do_pop_s);

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      level_d = level_q;
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
      end
   end

   // Storage array; cleared on reset so no stale entry is ever visible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_s;
   assign empty_o = empty_s;
   assign level_o = level_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Turns CPU LCD-register writes into timed HD44780 write cycles via a request FIFO.
module lcd_write_sequencer
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int T_SETUP_CYC = 4,
   parameter int T_EN_CYC    = 25,
   parameter int T_HOLD_CYC  = 2,
   parameter int T_EXEC_CYC  = 2500,
   parameter int T_CLEAR_CYC = 82000
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [31:0]                   i_lcd_reg,
   output logic                          o_lcd_on,
   output logic                          o_lcd_en,
   output logic                          o_lcd_rs,
   output logic                          o_lcd_rw,
   output logic [7:0]                    o_lcd_data,
   output logic                          o_busy,
   output logic                          o_drop,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int T_MAX_A = (T_SETUP_CYC > T_EN_CYC)   ? T_SETUP_CYC : T_EN_CYC;
   localparam int T_MAX_B = (T_HOLD_CYC  > T_EXEC_CYC) ? T_HOLD_CYC  : T_EXEC_CYC;
   localparam int T_MAX_C = (T_MAX_A > T_MAX_B)         ? T_MAX_A     : T_MAX_B;
   localparam int T_MAX   = (T_MAX_C > T_CLEAR_CYC)     ? T_MAX_C     : T_CLEAR_CYC;
   localparam int CNT_W   = $clog2(T_MAX) + 1;
   localparam int ENTRY_W = $bits(lcd_entry_t);
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

   // Captured register fields.
   logic             on_q;
   logic             en_in_q;
   logic             rs_in_q;
   logic [7:0]       data_in_q;
   logic             seeded_q;
   logic             en_prev_q;

   // FSM and output registers.
   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   lcd_entry_t       out_q, out_d;
   logic             drop_q, drop_d;

   // FIFO interface.
   logic               push_s;
   logic               pop_s;
   logic [ENTRY_W-1:0] push_entry_s;
   logic [ENTRY_W-1:0] fifo_rdata_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [LVL_W-1:0]   fifo_level_s;

   // RW and the spare register bits carry nothing for a write-only interface.
   logic unused_s;
   assign unused_s = ^{i_lcd_reg[30:11], i_lcd_reg[LCD_RW_BIT]};

   // Register the CPU LCD register every cycle; the first sample after reset seeds
   // the EN history so a level already high out of reset is not taken as a request.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         on_q      <= 1'b0;
         en_in_q   <= 1'b0;
         rs_in_q   <= 1'b0;
         data_in_q <= 8'h00;
         seeded_q  <= 1'b0;
         en_prev_q <= 1'b0;
      end else begin
         on_q      <= i_lcd_reg[LCD_ON_BIT];
         en_in_q   <= i_lcd_reg[LCD_EN_BIT];
         rs_in_q   <= i_lcd_reg[LCD_RS_BIT];
         data_in_q <= i_lcd_reg[7:0];
         seeded_q  <= 1'b1;
         en_prev_q <= seeded_q ? en_in_q : i_lcd_reg[LCD_EN_BIT];
      end
   end

   // A request is a rising edge of the registered EN bit.
   assign push_s       = en_in_q & ~en_prev_q;
   assign push_entry_s = {rs_in_q, data_in_q};

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (push_entry_s),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .level_o (fifo_level_s)
   );

   // A request is lost only when the FIFO is full and nothing leaves it this cycle.
   assign drop_d = push_s & fifo_full_s & ~pop_s;

   // Write-cycle FSM: one down-counter reloaded on every state entry, firing at 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      out_d   = out_q;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            en_d = 1'b0;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               out_d   = lcd_entry_t'(fifo_rdata_s);
               state_d = S_SETUP;
               cnt_d   = CNT_W'(T_SETUP_CYC);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_PULSE;
               en_d    = 1'b1;
               cnt_d   = CNT_W'(T_EN_CYC);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_PULSE: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_HOLD;
               en_d    = 1'b0;
               cnt_d   = CNT_W'(T_HOLD_CYC);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_EXEC;
               cnt_d   = is_long_cmd(out_q) ? CNT_W'(T_CLEAR_CYC) : CNT_W'(T_EXEC_CYC);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_EXEC: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM state, counter and pin registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         en_q    <= 1'b0;
         out_q   <= '{rs: 1'b0, data: 8'h00};
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   assign o_lcd_on     = on_q;
   assign o_lcd_en     = en_q;
   assign o_lcd_rs     = out_q.rs;
   assign o_lcd_data   = out_q.data;
   assign o_lcd_rw     = 1'b0;
   assign o_busy       = (state_q != S_IDLE) | ~fifo_empty_s;
   assign o_drop       = drop_q;
   assign o_fifo_level = fifo_level_s;

endmodule
